// File: rtl/minimax_dbus_responder.sv
// Data-bus target for the minimax core: byte-writable RAM, console word, halt flag and programmable read wait states.
// Define DBUS_ERR_EN to add the err_sticky output that flags ignored or dropped bus activity.

module minimax_dbus_responder #(
    parameter int unsigned RAM_BYTES    = 4096,
    parameter int unsigned READ_WAIT    = 0,
    parameter logic [31:0] CONSOLE_ADDR = 32'hfffffff8,
    parameter logic [31:0] HALT_ADDR    = 32'hfffffffc
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rreq,
    output logic        rack,
    output logic [31:0] rdata,
    output logic        console_valid,
    output logic [31:0] console_data,
`ifdef DBUS_ERR_EN
    output logic        err_sticky,
`endif
    output logic        halted
);

    localparam int unsigned IDX_W     = $clog2(RAM_BYTES) - 2;
    localparam int unsigned WORDS     = RAM_BYTES / 4;
    localparam logic [29:0] RAM_WORDS = 30'(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [29:0]      rd_word;
    logic [31:0]      console_count;
    logic [31:0]      mem [WORDS];

    logic [29:0]      wr_word;
    logic [29:0]      eff_word;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] eff_idx;
    logic             wr_any;
    logic             wr_ram_hit;
    logic             wr_con_hit;
    logic             wr_halt_hit;
    logic             full_mask;
    logic             ram_wr;
    logic             con_wr;
    logic             halt_wr;
    logic [31:0]      count_next;
    logic             halted_next;
    logic [31:0]      merged_word;
    logic [31:0]      read_value;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    assign wr_word     = addr[31:2];
    assign wr_idx      = addr[IDX_W+1:2];
    assign wr_any      = |wmask;
    assign full_mask   = (wmask == 4'hf);
    assign wr_ram_hit  = (wr_word < RAM_WORDS);
    assign wr_con_hit  = (wr_word == CONSOLE_ADDR[31:2]);
    assign wr_halt_hit = (wr_word == HALT_ADDR[31:2]);

    assign ram_wr  = wr_any && !halted && wr_ram_hit;
    assign con_wr  = !halted && full_mask && wr_con_hit;
    assign halt_wr = !halted && full_mask && wr_halt_hit;

    assign count_next  = con_wr ? console_count + 32'd1 : console_count;
    assign halted_next = halted | halt_wr;

    // In IDLE the read address is being captured this very edge, so decode the live bus address.
    assign eff_word = (state == S_IDLE) ? addr[31:2] : rd_word;
    assign eff_idx  = eff_word[IDX_W-1:0];

    // Write-before-read: lanes written on the sampling edge bypass into the returned word.
    always_comb begin
        merged_word = mem[eff_idx];
        for (int i = 0; i < 4; i++) begin
            if (ram_wr && (wr_idx == eff_idx) && wmask[i]) begin
                merged_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        read_value = 32'h0;
        if (eff_word < RAM_WORDS) begin
            read_value = merged_word;
        end else if (eff_word == CONSOLE_ADDR[31:2]) begin
            read_value = count_next;
        end else if (eff_word == HALT_ADDR[31:2]) begin
            read_value = {31'b0, halted_next};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            console_valid <= 1'b0;
            console_data  <= 32'h0;
            console_count <= 32'h0;
            halted        <= 1'b0;
        end else begin
            console_valid <= con_wr;
            console_count <= count_next;
            halted        <= halted_next;
            if (con_wr) begin
                console_data <= wdata;
            end
        end
    end

    // Read FSM: rack is high for the single cycle spent in ACK, with rdata loaded on the entering edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= 4'h0;
            rd_word  <= 30'h0;
            rack     <= 1'b0;
            rdata    <= 32'h0;
        end else begin
            rack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rreq) begin
                        rd_word <= addr[31:2];
                        if (READ_WAIT == 0) begin
                            state <= S_ACK;
                            rack  <= 1'b1;
                            rdata <= read_value;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(READ_WAIT - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'h0) begin
                        state <= S_ACK;
                        rack  <= 1'b1;
                        rdata <= read_value;
                    end else begin
                        wait_cnt <= wait_cnt - 4'h1;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DBUS_ERR_EN
    logic err_set;

    assign err_set = (wr_any && halted)
                   || (wr_any && !halted && !wr_ram_hit && !wr_con_hit && !wr_halt_hit)
                   || (wr_any && (wr_con_hit || wr_halt_hit) && !full_mask)
                   || (rreq && (state != S_IDLE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule
